// File: rtl/ahb3lite_burst_write_master.sv
// ahb3lite_burst_write_master: AHB3-Lite write-only burst master with wait-state, 1KB-boundary and error handling
// Ports: HCLK/HRESET bus clock and async active-high reset; cmd_valid/cmd_ready/cmd_addr/cmd_beats burst command;
//   wdata_valid/wdata_ready/wdata write-word stream; HADDR..HWDATA, HREADY, HRESP AHB3-Lite master side;
//   done one-cycle completion pulse; err sticky error flag cleared on the next accepted command.
module ahb3lite_burst_write_master #(
  parameter int         MAX_BEATS = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [4:0]  cmd_beats,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        done,
  output logic        err
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DRAIN = 2'd2, S_ERR = 2'd3;
  logic [1:0]  r_state;
  logic [31:0] r_addr, r_hwdata;
  logic [4:0]  r_left;
  logic [2:0]  r_burst;
  logic        r_first, r_started, r_err;
  logic [4:0]  w_beats;
  logic [8:0]  w_end;
  logic [2:0]  w_burst;
  logic [31:0] w_next;
  logic [1:0]  w_trans;
  logic        w_accept, w_fault;
  assign w_beats = cmd_beats == 5'd0 ? 5'd1 : cmd_beats > 5'(MAX_BEATS) ? 5'(MAX_BEATS) : cmd_beats;
  // word index one past the last beat; above 256 the burst leaves its 1KB region
  assign w_end = {1'b0, cmd_addr[9:2]} + {4'd0, w_beats};
  assign w_burst = w_beats == 5'd1 ? 3'b000 : w_end > 9'd256 ? 3'b001 :
                   w_beats == 5'd4 ? 3'b011 : w_beats == 5'd8 ? 3'b101 :
                   w_beats == 5'd16 ? 3'b111 : 3'b001;
  assign w_next = r_addr + 32'd4;
  // no data yet: IDLE before the first beat, BUSY once the burst has started
  assign w_trans = r_state != S_ADDR ? 2'b00 : wdata_valid ? (r_first ? 2'b10 : 2'b11) :
                   (r_started ? 2'b01 : 2'b00);
  assign w_accept = r_state == S_ADDR && wdata_valid && HREADY;
  // first cycle of the two-cycle ERROR response: the pending beat can still be withdrawn
  assign w_fault = HRESP && !HREADY;
  assign cmd_ready = r_state == S_IDLE;
  assign wdata_ready = w_accept;
  assign HADDR = r_addr;
  assign HTRANS = w_trans;
  assign HBURST = r_burst;
  assign HSIZE = 3'b010;
  assign HWRITE = w_trans != 2'b00;
  assign HPROT = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA = r_hwdata;
  assign done = HREADY && (r_state == S_DRAIN || r_state == S_ERR);
  assign err = r_err;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_addr <= 32'd0;
      r_hwdata <= 32'd0;
      r_left <= 5'd0;
      r_burst <= 3'b000;
      r_first <= 1'b0;
      r_started <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_hwdata <= wdata;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_state <= S_ADDR;
          r_addr <= cmd_addr & ~32'd3;
          r_left <= w_beats;
          r_burst <= w_burst;
          r_first <= 1'b1;
          r_started <= 1'b0;
          r_err <= 1'b0;
        end
        S_ADDR: if (w_fault) begin
          r_state <= S_ERR;
          r_err <= 1'b1;
        end else if (w_accept) begin
          r_addr <= w_next;
          r_left <= r_left - 5'd1;
          r_first <= w_next[9:0] == 10'd0;
          r_started <= 1'b1;
          if (r_left == 5'd1) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_fault) begin
          r_state <= S_ERR;
          r_err <= 1'b1;
        end else if (HREADY) r_state <= S_IDLE;
        default: if (HREADY) r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb3lite_burst_write_master.sv
// tb_ahb3lite_burst_write_master: table-driven and scoreboard bench for the AHB3-Lite burst write master
module tb_ahb3lite_burst_write_master;
  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = 32'd0;
  logic [4:0]  cmd_beats = 5'd0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = 32'd0;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic        HWRITE, HMASTLOCK;
  logic [3:0]  HPROT;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic        done, err;

  ahb3lite_burst_write_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .wdata(wdata), .HADDR(HADDR), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  beats;
    int          stall_at;
    int          stall_len;
    int          wait_at;
    int          wait_len;
    logic [2:0]  exp_burst;
    int          exp_n;
    int          exp_cyc;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] data;
  } beat_t;

  vec_t  vecs[12];
  beat_t sb[$];
  beat_t e;
  int n_cmp = 0, n_bad = 0, wr_cnt = 0, done_cnt = 0;
  logic mon_en = 1'b0, dp_valid = 1'b0;
  logic [31:0] dp_exp = 32'd0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(int i, int k);
    return i == 0 ? 32'hA5A5A5A5 : {16'hC0DE, 8'(i), 8'(k)};
  endfunction

  always @(negedge HCLK) begin
    if (wdata_ready) wr_cnt++;
    if (done) begin
      done_cnt++;
      chk("done_vs_cmd_ready", cmd_ready, 0);
    end
    if (mon_en) begin
      if (dp_valid) begin
        chk("hwdata", HWDATA, dp_exp);
        if (HREADY) dp_valid = 1'b0;
      end
      if (HTRANS[1]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got HADDR %h HTRANS %b with no beat expected", HADDR, HTRANS);
        end else begin
          e = sb[0];
          chk("haddr", HADDR, e.addr);
          chk("htrans", HTRANS, e.trans);
          chk("hburst", HBURST, e.burst);
          chk("hwrite", HWRITE, 1);
          if (HREADY) begin
            chk("wdata_ready", wdata_ready, 1);
            dp_valid = 1'b1;
            dp_exp = e.data;
            void'(sb.pop_front());
          end
        end
      end else chk("wdata_ready_idle", wdata_ready, 0);
    end
  end

  task automatic run_vec(int i);
    vec_t v;
    beat_t b;
    int base, d0, k, sc, wc, cyc;
    logic [31:0] a;
    logic stall, wt;
    v = vecs[i];
    sc = 0;
    wc = 0;
    cyc = 0;
    for (int j = 0; j < v.exp_n; j++) begin
      a = (v.addr & ~32'd3) + 32'(4 * j);
      b.addr = a;
      b.trans = (j == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
      b.burst = v.exp_burst;
      b.data = dat(i, j);
      sb.push_back(b);
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr = v.addr;
    cmd_beats = v.beats;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    base = wr_cnt;
    d0 = done_cnt;
    while (done_cnt == d0 && cyc < 200) begin
      k = wr_cnt - base;
      stall = k == v.stall_at && sc < v.stall_len;
      if (stall) sc++;
      wdata_valid = !stall && k < v.exp_n;
      wdata = dat(i, k);
      wt = wdata_valid && k == v.wait_at && wc < v.wait_len;
      if (wt) wc++;
      HREADY = !wt;
      #1;
      if (cyc == 0) begin
        chk("err_cleared", err, 0);
        chk("cmd_ready_busy", cmd_ready, 0);
      end
      if (stall) chk("stall_htrans", HTRANS, k > 0 ? 2'b01 : 2'b00);
      @(posedge HCLK); #1;
      cyc++;
    end
    wdata_valid = 1'b0;
    HREADY = 1'b1;
    chk("cycles", cyc, v.exp_cyc);
    chk("beats", wr_cnt - base, v.exp_n);
    chk("done_pulses", done_cnt - d0, 1);
    chk("sb_empty", sb.size(), 0);
    chk("done_low", done, 0);
    sb.delete();
  endtask

  initial begin
    int base, d0;
    //          addr          beats stall    wait     burst   n   cyc
    vecs[0]  = '{32'h0000_0100, 5'd1,  0, 0, 0, 0, 3'b000, 1,  2};
    vecs[1]  = '{32'h0000_0200, 5'd4,  0, 0, 0, 0, 3'b011, 4,  5};
    vecs[2]  = '{32'h0000_1000, 5'd8,  0, 0, 2, 2, 3'b101, 8,  11};
    vecs[3]  = '{32'h0000_0300, 5'd6,  2, 3, 0, 0, 3'b001, 6,  10};
    vecs[4]  = '{32'h0000_03F8, 5'd4,  0, 0, 0, 0, 3'b001, 4,  5};
    vecs[5]  = '{32'h0000_02C0, 5'd16, 0, 0, 0, 0, 3'b111, 16, 17};
    vecs[6]  = '{32'h0000_03C0, 5'd16, 0, 0, 0, 0, 3'b111, 16, 17};
    vecs[7]  = '{32'h0000_03E4, 5'd8,  0, 0, 0, 0, 3'b001, 8,  9};
    vecs[8]  = '{32'h0000_0047, 5'd0,  0, 0, 0, 0, 3'b000, 1,  2};
    vecs[9]  = '{32'h0000_0800, 5'd20, 0, 0, 0, 0, 3'b111, 16, 17};
    vecs[10] = '{32'h0000_0040, 5'd5,  0, 2, 0, 0, 3'b001, 5,  8};
    vecs[11] = '{32'h0000_07FC, 5'd2,  0, 0, 1, 1, 3'b001, 2,  4};
    #1;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hburst", HBURST, 3'b000);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("hsize", HSIZE, 3'b010);
    chk("hprot", HPROT, 4'b0011);
    chk("hmastlock", HMASTLOCK, 0);
    #12 HRESET = 1'b0;
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) run_vec(i);
    mon_en = 1'b0;
    // error response on the data phase of beat 2 of an INCR4
    cmd_valid = 1'b1;
    cmd_addr = 32'h500;
    cmd_beats = 5'd4;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    base = wr_cnt;
    d0 = done_cnt;
    wdata_valid = 1'b1;
    wdata = 32'hE0000001;
    #1;
    chk("err_first_htrans", HTRANS, 2'b10);
    chk("err_first_haddr", HADDR, 32'h500);
    @(posedge HCLK); #1;
    wdata = 32'hE0000002;
    @(posedge HCLK); #1;
    wdata = 32'hE0000003;
    HREADY = 1'b0;
    HRESP = 1'b1;
    #1;
    chk("err_cyc1_htrans", HTRANS, 2'b11);
    chk("err_cyc1_haddr", HADDR, 32'h508);
    chk("err_cyc1_wdata_ready", wdata_ready, 0);
    chk("err_cyc1_hwdata", HWDATA, 32'hE0000002);
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    #1;
    chk("err_cyc2_htrans", HTRANS, 2'b00);
    chk("err_cyc2_hwrite", HWRITE, 0);
    chk("err_flag", err, 1);
    chk("err_done", done, 1);
    @(posedge HCLK); #1;
    HRESP = 1'b0;
    wdata_valid = 1'b0;
    #1;
    chk("err_after_done", done, 0);
    chk("err_after_cmd_ready", cmd_ready, 1);
    chk("err_sticky", err, 1);
    chk("err_wr_pulses", wr_cnt - base, 2);
    chk("err_done_pulses", done_cnt - d0, 1);
    dp_valid = 1'b0;
    sb.delete();
    mon_en = 1'b1;
    run_vec(0);
    mon_en = 1'b0;
    // asynchronous reset in the middle of an INCR8
    cmd_valid = 1'b1;
    cmd_addr = 32'h600;
    cmd_beats = 5'd8;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    wdata_valid = 1'b1;
    wdata = 32'h11111111;
    repeat (3) @(posedge HCLK);
    #1;
    chk("pre_reset_htrans", HTRANS, 2'b11);
    #1;
    HRESET = 1'b1;
    #1;
    chk("arst_htrans", HTRANS, 2'b00);
    chk("arst_hwrite", HWRITE, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_haddr", HADDR, 0);
    chk("arst_hwdata", HWDATA, 0);
    chk("arst_hburst", HBURST, 3'b000);
    chk("arst_wdata_ready", wdata_ready, 0);
    wdata_valid = 1'b0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    chk("post_reset_htrans", HTRANS, 2'b00);
    dp_valid = 1'b0;
    sb.delete();
    mon_en = 1'b1;
    run_vec(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
